y86_seq_controller: RTL
=======================

Name: y86_seq_controller

Overview:
Multi-cycle stage sequencer for the Y86-64 SEQ core. It steps fetch, decode, execute, memory, write-back and PC-update one stage per clock, handles the data-memory request/acknowledge handshake and tracks the architectural status code. It replaces the ad-hoc halt-on-error check with a proper HALTED state, and keeps cycle and retired-instruction counters. It sits beside the stage modules in the processor top and drives their enables.

Parameters:
CNT_W, 32, width of cycle_count and instr_count (wrap-around counters).
MEM_TIMEOUT, 16, max cycles MEMORY waits for mem_ack before flagging ADR (must be >=1).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  begin or resume execution from IDLE.
stop_req  input  1  return to IDLE after the current instruction retires.
icode  input  4  icode from fetch, valid at the end of the FETCH cycle.
instruct_err  input  1  invalid instruction flag from fetch.
imem_err  input  1  instruction-memory address error from fetch.
mem_ack  input  1  data memory has completed the request.
dmem_err  input  1  data-memory address error, qualified by mem_ack.
stage_en  output  6  one-hot stage enable {pcupd,wb,mem,exe,dec,fetch}, bit0 = fetch.
mem_req  output  1  data memory request, held until ack or timeout.
pc_we  output  1  PC register write enable (equals stage_en[5]).
stat  output  3  Y86 status: AOK=1, HLT=2, ADR=3, INS=4.
halted  output  1  core stopped in HALTED.
busy  output  1  state is neither IDLE nor HALTED.
cycle_count  output  CNT_W  cycles spent while busy.
instr_count  output  CNT_W  retired instructions.

Behaviour:
- All outputs are registered or decoded from state only (Moore). There is no combinational path from inputs to outputs.
- Reset (async assert, sync release) values:
  - state IDLE;
  - stage_en 0, mem_req 0, pc_we 0;
  - stat AOK, halted 0, busy 0;
  - both counters 0.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALTED. Exactly one stage_en bit is high in each stage state; none in IDLE or HALTED.
- IDLE: start=1 -> FETCH next cycle; otherwise stay.
- FETCH (1 cycle): latch icode into icode_q. Next state, in priority order:
  - imem_err -> HALTED, stat=ADR;
  - else instruct_err -> HALTED, stat=INS;
  - else icode==0 -> HALTED, stat=HLT;
  - else DECODE.
- DECODE -> EXECUTE -> MEMORY, one cycle each.
- MEMORY, when icode_q is in {4,5,8,9,A,B} (memory-referencing instructions):
  - mem_req=1 from the first MEMORY cycle; a wait counter starts at 0 and increments each cycle.
  - mem_ack=1 and dmem_err=1 -> HALTED, stat=ADR.
  - mem_ack=1 and dmem_err=0 -> WRITEBACK.
  - No ack by the end of the MEMORY_TIMEOUT-th cycle -> HALTED, stat=ADR.
  - An ack on the same cycle as the timeout wins.
  - mem_req drops the cycle after leaving MEMORY.
- MEMORY, for all other icodes: one cycle, no mem_req, dmem_err ignored.
- WRITEBACK (1 cycle) -> PCUPD.
- PCUPD (1 cycle): pc_we=1 and instr_count increments. Next state is IDLE if stop_req was seen since the last FETCH (sticky flag, cleared on entering FETCH); otherwise FETCH.
- HALTED: absorbing; only rst leaves it.
  - halted=1; stat is held; start and stop_req are ignored.
  - Error paths never assert pc_we and never increment instr_count.
- cycle_count increments on every clock while busy=1 and wraps modulo 2^CNT_W. instr_count also wraps.
- stop_req asserted in IDLE has no effect. start asserted while busy is ignored.
- rst asserted mid-instruction (including mid-handshake): all outputs go to reset values immediately and mem_req drops asynchronously.

Decomposition:
- Shared package y86_pkg holds:
  - stat codes AOK/HLT/ADR/INS;
  - icode constants (HALT=0, RMMOVQ=4, MRMOVQ=5, CALL=8, RET=9, PUSHQ=A, POPQ=B);
  - the state encoding;
  - the stage_en bit indices.
- One natural sub-module: y86_mem_handshake, which owns the wait counter, mem_req, and the ack/timeout/error resolution, and returns done/err to the main FSM.

Test Plan:
- Reset, start, icode=6 (OPq) throughout, stop_req pulsed during DECODE:
  - stage_en walks 01,02,04,08,10,20, one per cycle;
  - pc_we high only in cycle 6;
  - ends in IDLE with instr_count=1 and cycle_count=6.
- Run with icode=5 and mem_ack arriving on the 3rd MEMORY cycle:
  - mem_req high for exactly 3 cycles;
  - instruction takes 8 cycles;
  - stat=AOK.
- icode=4, mem_ack never, MEM_TIMEOUT=16:
  - HALTED after 16 MEMORY cycles, stat=3, halted=1;
  - no pc_we; instr_count unchanged.
- FETCH with imem_err=1 and instruct_err=1 in the same cycle -> stat=3 (ADR wins).
  - Repeat with only instruct_err=1 -> stat=4.
- Third instruction has icode=0 -> stat=2, HALTED, instr_count=2; a later start pulse causes no state change.
- rst pulsed while mem_req=1 -> mem_req=0 and state IDLE without waiting for a clock edge; both counters 0.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 SEQ controller: status codes, icodes,
// sequencer state encoding and stage-enable bit positions.
package y86_pkg;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_PCUPD     = 3'd6,
    S_HALTED    = 3'd7
  } state_e;

  localparam int EN_FETCH = 0;
  localparam int EN_DEC   = 1;
  localparam int EN_EXE   = 2;
  localparam int EN_MEM   = 3;
  localparam int EN_WB    = 4;
  localparam int EN_PCUPD = 5;

  // True for instructions that touch data memory in the MEMORY stage.
  function automatic logic is_mem_icode(input logic [3:0] ic);
    case (ic)
      I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: is_mem_icode = 1'b1;
      default:                                           is_mem_icode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/y86_mem_handshake.sv
// Data-memory request/acknowledge handshake. The request is held while the
// sequencer sits in a memory-referencing MEMORY cycle; a wait counter bounds
// the wait, and ack/error/timeout are resolved into done/err for the FSM.
module y86_mem_handshake
  import y86_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic mem_ack,
  input  logic dmem_err,
  output logic mem_req,
  output logic done,
  output logic err
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;

  // active is derived from registered state only, so mem_req stays Moore and
  // falls asynchronously with the sequencer reset.
  assign mem_req = active;

  // Wait counter: 0 in the first MEMORY cycle, counts up while waiting.
  always_comb begin
    wait_d = '0;
    if (active) wait_d = wait_q + WAIT_W'(1);
  end

  // Resolve the handshake; an ack on the final wait cycle beats the timeout.
  always_comb begin
    done = 1'b0;
    err  = 1'b0;
    if (active) begin
      if (mem_ack) begin
        done = ~dmem_err;
        err  = dmem_err;
      end else if (wait_q == WAIT_LAST) begin
        err = 1'b1;
      end
    end
  end

  // Wait counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_q <= '0;
    else     wait_q <= wait_d;
  end

endmodule

// File: rtl/y86_seq_controller.sv
// Multi-cycle stage sequencer for the Y86-64 SEQ core: one stage per clock,
// data-memory handshake, architectural status tracking, HALTED state and
// cycle / retired-instruction counters. All outputs are Moore.
module y86_seq_controller
  import y86_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop_req,
  input  logic [3:0]       icode,
  input  logic             instruct_err,
  input  logic             imem_err,
  input  logic             mem_ack,
  input  logic             dmem_err,
  output logic [5:0]       stage_en,
  output logic             mem_req,
  output logic             pc_we,
  output logic [2:0]       stat,
  output logic             halted,
  output logic             busy,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  stat_e            stat_q, stat_d;
  logic [3:0]       icode_q, icode_d;
  logic             stop_q, stop_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instr_q, instr_d;

  logic mem_active;
  logic hs_done;
  logic hs_err;

  assign mem_active = (state_q == S_MEMORY) && is_mem_icode(icode_q);

  y86_mem_handshake #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_hs (
    .clk     (clk),
    .rst     (rst),
    .active  (mem_active),
    .mem_ack (mem_ack),
    .dmem_err(dmem_err),
    .mem_req (mem_req),
    .done    (hs_done),
    .err     (hs_err)
  );

  // Next-state logic: stage sequencing, error routing into HALTED, status.
  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    icode_d = icode_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        icode_d = icode;
        if (imem_err) begin
          state_d = S_HALTED;
          stat_d  = STAT_ADR;
        end else if (instruct_err) begin
          state_d = S_HALTED;
          stat_d  = STAT_INS;
        end else if (icode == I_HALT) begin
          state_d = S_HALTED;
          stat_d  = STAT_HLT;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: state_d = S_MEMORY;
      S_MEMORY: begin
        if (!mem_active) begin
          state_d = S_WRITEBACK;
        end else if (hs_err) begin
          state_d = S_HALTED;
          stat_d  = STAT_ADR;
        end else if (hs_done) begin
          state_d = S_WRITEBACK;
        end
      end
      S_WRITEBACK: state_d = S_PCUPD;
      S_PCUPD:     state_d = (stop_q || stop_req) ? S_IDLE : S_FETCH;
      S_HALTED:    state_d = S_HALTED;
      default:     state_d = S_IDLE;
    endcase
  end

  // Sticky stop request and the two wrap-around counters.
  always_comb begin
    stop_d  = stop_q | (stop_req & busy);
    if (state_d == S_FETCH) stop_d = 1'b0;
    cycle_d = cycle_q;
    if (busy) cycle_d = cycle_q + CNT_W'(1);
    instr_d = instr_q;
    if (state_q == S_PCUPD) instr_d = instr_q + CNT_W'(1);
  end

  // Output decode from the current state.
  always_comb begin
    stage_en = '0;
    case (state_q)
      S_FETCH:     stage_en[EN_FETCH] = 1'b1;
      S_DECODE:    stage_en[EN_DEC]   = 1'b1;
      S_EXECUTE:   stage_en[EN_EXE]   = 1'b1;
      S_MEMORY:    stage_en[EN_MEM]   = 1'b1;
      S_WRITEBACK: stage_en[EN_WB]    = 1'b1;
      S_PCUPD:     stage_en[EN_PCUPD] = 1'b1;
      default:     stage_en = '0;
    endcase
  end

  assign pc_we       = stage_en[EN_PCUPD];
  assign stat        = stat_q;
  assign halted      = (state_q == S_HALTED);
  assign busy        = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign cycle_count = cycle_q;
  assign instr_count = instr_q;

  // State, status and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      stat_q  <= STAT_AOK;
      icode_q <= '0;
      stop_q  <= 1'b0;
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      icode_q <= icode_d;
      stop_q  <= stop_d;
      cycle_q <= cycle_d;
      instr_q <= instr_d;
    end
  end

endmodule
